// File: rtl/display_pkg.sv
// Shared definitions for the display tile buffer.
// FSM encodings, fill defaults, attribute offsets, clog2.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_CLEAR       = 2'd1,
        ST_SCROLL_FILL = 2'd2
    } fill_state_e;

    localparam logic [7:0] FILL_CHAR_DEF = 8'h20;
    localparam logic [7:0] FILL_ATTR_DEF = 8'h0F;

    localparam int ATTR_BG_LSB = 0;
    localparam int ATTR_FG_LSB = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/tile_ram_dp.sv
// True dual-port tile RAM with per-field write enables on port A.
// Port A is write-first, port B read-first; both outputs registered.
module tile_ram_dp
    import display_pkg::*;
#(
    parameter int CHAR_W = 8,
    parameter int ATTR_W = 8,
    parameter int DEPTH  = 4800,
    localparam int W     = CHAR_W + ATTR_W,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    a_we,
    input  logic          a_re,
    input  logic [AW-1:0] a_addr,
    input  logic [W-1:0]  a_wdata,
    output logic [W-1:0]  a_rdata,
    input  logic          b_en,
    input  logic [AW-1:0] b_addr,
    output logic [W-1:0]  b_rdata
);

    (* ram_style = "block" *)
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] a_rdata_q;
    logic [W-1:0] b_rdata_q;

    // Port A field writes; contents are never reset.
    always_ff @(posedge clk) begin
        if (a_we[0]) mem_q[a_addr][CHAR_W-1:0] <= a_wdata[CHAR_W-1:0];
        if (a_we[1]) mem_q[a_addr][W-1:CHAR_W] <= a_wdata[W-1:CHAR_W];
    end

    // Port A output register, refreshed only on reads, write-first merge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata_q <= '0;
        end else if (a_re) begin
            a_rdata_q[CHAR_W-1:0] <= a_we[0] ? a_wdata[CHAR_W-1:0]
                                             : mem_q[a_addr][CHAR_W-1:0];
            a_rdata_q[W-1:CHAR_W] <= a_we[1] ? a_wdata[W-1:CHAR_W]
                                             : mem_q[a_addr][W-1:CHAR_W];
        end
    end

    // Port B output register; sees the pre-write contents on collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_rdata_q <= '0;
        end else if (b_en) begin
            b_rdata_q <= mem_q[b_addr];
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/display_tile_buffer.sv
// Character/attribute tile buffer with vertical scroll
// and a self-timed clear/fill engine on RAM port A.
module display_tile_buffer
    import display_pkg::*;
#(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int CHAR_W = 8,
    parameter int ATTR_W = 8,
    parameter logic [CHAR_W-1:0] FILL_CHAR = FILL_CHAR_DEF,
    parameter logic [ATTR_W-1:0] FILL_ATTR = FILL_ATTR_DEF,
    localparam int W     = CHAR_W + ATTR_W,
    localparam int DEPTH = COLS * ROWS,
    localparam int CW    = clog2(COLS),
    localparam int RW    = clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_en,
    input  logic          a_we,
    input  logic [1:0]    a_be,
    input  logic [CW-1:0] a_col,
    input  logic [RW-1:0] a_row,
    input  logic [W-1:0]  a_wdata,
    output logic          a_ready,
    output logic [W-1:0]  a_rdata,
    input  logic          b_en,
    input  logic [CW-1:0] b_col,
    input  logic [RW-1:0] b_row,
    output logic [W-1:0]  b_rdata,
    output logic          b_valid,
    input  logic          cmd_clear,
    input  logic          cmd_scroll,
    output logic          busy,
    output logic [RW-1:0] row_base
);

    localparam int AW = clog2(DEPTH);
    localparam logic [W-1:0] FILL_WORD = {FILL_ATTR, FILL_CHAR};

    fill_state_e   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] fill_base_q, fill_base_d;
    logic [RW-1:0] row_base_q, row_base_d;
    logic          a_oor_q, b_oor_q, b_valid_q;

    logic          a_acc, a_ok, b_ok;
    logic [AW-1:0] a_phys, b_phys;
    logic [1:0]    ram_a_we;
    logic          ram_a_re;
    logic [AW-1:0] ram_a_addr;
    logic [W-1:0]  ram_a_wdata;
    logic [W-1:0]  ram_a_rdata, ram_b_rdata;

    function automatic logic [AW-1:0] phys_addr(
        input logic [CW-1:0] col,
        input logic [RW-1:0] row,
        input logic [RW-1:0] base
    );
        logic [RW:0] prow;
        prow = {1'b0, row} + {1'b0, base};
        if (prow >= (RW+1)'(ROWS)) prow = prow - (RW+1)'(ROWS);
        return AW'(prow) * AW'(COLS) + AW'(col);
    endfunction

    function automatic logic in_range(
        input logic [CW-1:0] col,
        input logic [RW-1:0] row
    );
        return ({1'b0, col} < (CW+1)'(COLS)) &&
               ({1'b0, row} < (RW+1)'(ROWS));
    endfunction

    assign a_ready = (state_q == ST_IDLE);
    assign busy    = !a_ready;
    assign a_acc   = a_en && a_ready;
    assign a_ok    = in_range(a_col, a_row);
    assign b_ok    = in_range(b_col, b_row);
    assign a_phys  = phys_addr(a_col, a_row, row_base_q);
    assign b_phys  = phys_addr(b_col, b_row, row_base_q);

    // Fill engine state, progress counter and scroll pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fill_base_q <= '0;
            row_base_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_base_q <= fill_base_d;
            row_base_q  <= row_base_d;
        end
    end

    // Command decode and fill sequencing; clear beats scroll.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_base_d = fill_base_q;
        row_base_d  = row_base_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cmd_clear) begin
                    state_d    = ST_CLEAR;
                    row_base_d = '0;
                end else if (cmd_scroll) begin
                    state_d     = ST_SCROLL_FILL;
                    fill_base_d = AW'(row_base_q) * AW'(COLS);
                    row_base_d  = (row_base_q == RW'(ROWS - 1))
                                ? '0 : row_base_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
            end
            ST_SCROLL_FILL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(COLS - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Port A mux: fill engine owns the RAM while busy.
    always_comb begin
        ram_a_we    = '0;
        ram_a_re    = 1'b0;
        ram_a_addr  = a_phys;
        ram_a_wdata = a_wdata;
        if (state_q == ST_CLEAR) begin
            ram_a_we    = 2'b11;
            ram_a_addr  = cnt_q;
            ram_a_wdata = FILL_WORD;
        end else if (state_q == ST_SCROLL_FILL) begin
            ram_a_we    = 2'b11;
            ram_a_addr  = fill_base_q + cnt_q;
            ram_a_wdata = FILL_WORD;
        end else if (a_acc && a_ok) begin
            ram_a_we = a_we ? a_be : 2'b00;
            ram_a_re = !a_we;
        end
    end

    // Out-of-range read flags and renderer valid strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_oor_q   <= 1'b0;
            b_oor_q   <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            if (a_acc && !a_we) a_oor_q <= !a_ok;
            if (b_en) b_oor_q <= !b_ok;
            b_valid_q <= b_en;
        end
    end

    tile_ram_dp #(
        .CHAR_W (CHAR_W),
        .ATTR_W (ATTR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .a_we    (ram_a_we),
        .a_re    (ram_a_re),
        .a_addr  (ram_a_addr),
        .a_wdata (ram_a_wdata),
        .a_rdata (ram_a_rdata),
        .b_en    (b_en && b_ok),
        .b_addr  (b_phys),
        .b_rdata (ram_b_rdata)
    );

    assign a_rdata  = a_oor_q ? FILL_WORD : ram_a_rdata;
    assign b_rdata  = b_oor_q ? FILL_WORD : ram_b_rdata;
    assign b_valid  = b_valid_q;
    assign row_base = row_base_q;

endmodule

// File: tb/tb_display_tile_buffer.sv
// Directed bench for display_tile_buffer (80x60 default).
// Linear stimulus with immediate-assertion checks.
module tb_display_tile_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, a_we;
    logic [1:0]  a_be;
    logic [6:0]  a_col;
    logic [5:0]  a_row;
    logic [15:0] a_wdata;
    logic        a_ready;
    logic [15:0] a_rdata;
    logic        b_en;
    logic [6:0]  b_col;
    logic [5:0]  b_row;
    logic [15:0] b_rdata;
    logic        b_valid;
    logic        cmd_clear, cmd_scroll;
    logic        busy;
    logic [5:0]  row_base;

    int ntests = 0;
    int nfail  = 0;

    display_tile_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .a_en       (a_en),
        .a_we       (a_we),
        .a_be       (a_be),
        .a_col      (a_col),
        .a_row      (a_row),
        .a_wdata    (a_wdata),
        .a_ready    (a_ready),
        .a_rdata    (a_rdata),
        .b_en       (b_en),
        .b_col      (b_col),
        .b_row      (b_row),
        .b_rdata    (b_rdata),
        .b_valid    (b_valid),
        .cmd_clear  (cmd_clear),
        .cmd_scroll (cmd_scroll),
        .busy       (busy),
        .row_base   (row_base)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_write(input int col, input int row,
                           input logic [15:0] d, input logic [1:0] be);
        bit acc;
        int n;
        n = 0;
        a_en = 1'b1; a_we = 1'b1; a_be = be;
        a_col = 7'(col); a_row = 6'(row); a_wdata = d;
        do begin
            acc = a_ready;
            cyc();
            n++;
        end while (!acc && n < 10000);
        a_en = 1'b0; a_we = 1'b0;
        if (!acc) check("a_write_timeout", 0, 1);
    endtask

    task automatic a_read(input int col, input int row,
                          output logic [15:0] d);
        bit acc;
        int n;
        n = 0;
        a_en = 1'b1; a_we = 1'b0;
        a_col = 7'(col); a_row = 6'(row);
        do begin
            acc = a_ready;
            cyc();
            n++;
        end while (!acc && n < 10000);
        a_en = 1'b0;
        d = a_rdata;
        if (!acc) check("a_read_timeout", 0, 1);
    endtask

    task automatic b_read(input int col, input int row,
                          output logic [15:0] d);
        b_en = 1'b1; b_col = 7'(col); b_row = 6'(row);
        cyc();
        b_en = 1'b0;
        d = b_rdata;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 20000) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        logic [15:0] d;
        int n, tot;

        rst = 1'b1; a_en = 0; a_we = 0; a_be = 0;
        a_col = 0; a_row = 0; a_wdata = 0;
        b_en = 0; b_col = 0; b_row = 0;
        cmd_clear = 0; cmd_scroll = 0;
        cyc(); cyc();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_row_base", row_base, 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_b_rdata", b_rdata, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_a_ready", a_ready, 1);

        // full clear
        cmd_clear = 1; cyc(); cmd_clear = 0;
        check("clear_busy_rise", busy, 1);
        check("clear_a_ready", a_ready, 0);
        wait_idle(n);
        check("clear_len", n, 4800);
        b_read(0, 0, d);   check("clr_0_0", d, 16'h0F20);
        check("b_valid_hi", b_valid, 1);
        cyc();             check("b_valid_lo", b_valid, 0);
        b_read(79, 59, d); check("clr_79_59", d, 16'h0F20);
        b_read(40, 30, d); check("clr_40_30", d, 16'h0F20);

        // byte enables
        a_write(5, 2, 16'h1E41, 2'b11);
        a_write(5, 2, 16'h0042, 2'b01);
        a_read(5, 2, d);   check("be_merge_a", d, 16'h1E42);
        b_read(5, 2, d);   check("be_merge_b", d, 16'h1E42);

        // fill every row r with char r
        for (int r = 0; r < 60; r++)
            for (int c = 0; c < 80; c++)
                a_write(c, r, {8'h07, 8'(r)}, 2'b11);
        b_read(10, 7, d);  check("fill_10_7", d, 16'h0707);

        // one scroll
        cmd_scroll = 1; cyc(); cmd_scroll = 0;
        check("scroll_row_base", row_base, 1);
        wait_idle(n);
        check("scroll_len", n, 80);
        b_read(3, 0, d);   check("scr_row0", d, 16'h0701);
        b_read(0, 58, d);  check("scr_row58", d, 16'h073B);
        b_read(0, 59, d);  check("scr_row59_c0", d, 16'h0F20);
        b_read(79, 59, d); check("scr_row59_c79", d, 16'h0F20);
        a_read(20, 0, d);  check("scr_a_row0", d, 16'h0701);

        // 59 more scrolls wrap row_base to 0
        tot = 0;
        for (int i = 0; i < 59; i++) begin
            cmd_scroll = 1; cyc(); cmd_scroll = 0;
            wait_idle(n);
            tot += n;
        end
        check("wrap_total_len", tot, 59 * 80);
        check("wrap_row_base", row_base, 0);
        b_read(5, 2, d);   check("wrap_all_filled", d, 16'h0F20);

        // clear wins over scroll; held write completes after busy
        cmd_scroll = 1; cyc(); cmd_scroll = 0;
        wait_idle(n);
        check("pre_both_row_base", row_base, 1);
        a_write(5, 2, 16'h1234, 2'b11);
        cmd_clear = 1; cmd_scroll = 1; cyc();
        cmd_clear = 0; cmd_scroll = 0;
        a_en = 1; a_we = 1; a_be = 2'b11;
        a_col = 9; a_row = 4; a_wdata = 16'hABCD;
        n = 0;
        while (!a_ready && n < 10000) begin
            cyc();
            n++;
        end
        check("both_stall_len", n, 4800);
        cyc();
        a_en = 0; a_we = 0;
        check("both_row_base", row_base, 0);
        b_read(9, 4, d);   check("held_write", d, 16'hABCD);
        b_read(5, 2, d);   check("both_cleared", d, 16'h0F20);
        a_read(9, 4, d);   check("held_write_a", d, 16'hABCD);
        a_write(1, 1, 16'h7777, 2'b11);
        check("a_rdata_hold", a_rdata, 16'hABCD);

        // out of range
        a_write(80, 0, 16'h5555, 2'b11);
        b_read(0, 1, d);   check("oor_write_drop", d, 16'h0F20);
        b_read(0, 60, d);  check("oor_b_row60", d, 16'h0F20);
        a_read(0, 60, d);  check("oor_a_row60", d, 16'h0F20);
        a_read(80, 0, d);  check("oor_a_col80", d, 16'h0F20);

        // A write / B read collision
        a_write(7, 7, 16'h1111, 2'b11);
        a_en = 1; a_we = 1; a_be = 2'b11;
        a_col = 7; a_row = 7; a_wdata = 16'h2222;
        b_en = 1; b_col = 7; b_row = 7;
        cyc();
        a_en = 0; a_we = 0; b_en = 0;
        check("collide_old", b_rdata, 16'h1111);
        b_read(7, 7, d);   check("collide_new", d, 16'h2222);

        // reset mid-clear
        cmd_clear = 1; cyc(); cmd_clear = 0;
        for (int i = 0; i < 100; i++) cyc();
        check("mid_clear_busy", busy, 1);
        rst = 1; cyc();
        check("rst_abort_busy", busy, 0);
        rst = 0; cyc();
        check("rst_abort_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
